// File: rtl/vga_timing_gen.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : VGA raster timing. Produces the pixel/line counters, sync and
//             blank decodes aligned with the counters, and a PIPE_DLY-deep
//             delayed copy of hs/vs/blank for the VGA pins. Also produces a
//             per-frame start pulse and a free-running 8-bit frame counter.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int PIPE_DLY  = 2
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       hs_d,
  output logic       vs_d,
  output logic       blank_d,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  // Raster geometry derived from the porch/sync parameters.
  localparam int         c_H_TOTAL    = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int         c_V_TOTAL    = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] c_H_LAST     = 10'(c_H_TOTAL - 1);
  localparam logic [9:0] c_V_LAST     = 10'(c_V_TOTAL - 1);
  localparam logic [9:0] c_H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] c_V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] c_HS_START   = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] c_HS_END     = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] c_VS_START   = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] c_VS_END     = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] r_draw_x;
  logic [9:0] r_draw_y;
  logic       r_blank;
  logic       r_hs;
  logic       r_vs;
  logic       r_frame_start;
  logic [7:0] r_frame_count;

  logic       w_h_wrap;
  logic       w_v_wrap;
  logic [9:0] w_h_next;
  logic [9:0] w_v_next;
  logic       w_blank_next;
  logic       w_hs_next;
  logic       w_vs_next;
  logic       w_frame_next;

  // Next counter values, and the decodes of those next values so the
  // registered sync/blank always describe the coordinates loaded with them.
  always_comb begin
    w_h_wrap = (r_draw_x == c_H_LAST);
    w_v_wrap = (r_draw_y == c_V_LAST);
    w_h_next = w_h_wrap ? 10'd0 : r_draw_x + 10'd1;
    w_v_next = r_draw_y;
    if (w_h_wrap) begin
      w_v_next = w_v_wrap ? 10'd0 : r_draw_y + 10'd1;
    end
    w_blank_next = (w_h_next < c_H_VIS) && (w_v_next < c_V_VIS);
    w_hs_next    = !((w_h_next >= c_HS_START) && (w_h_next < c_HS_END));
    w_vs_next    = !((w_v_next >= c_VS_START) && (w_v_next < c_VS_END));
    w_frame_next = w_h_wrap && w_v_wrap;
  end

  // Counter, decode and frame registers. Reset parks the raster on the last
  // pixel so the first edge after release lands exactly on (0,0).
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_draw_x      <= c_H_LAST;
      r_draw_y      <= c_V_LAST;
      r_blank       <= 1'b0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_frame_start <= 1'b0;
      r_frame_count <= 8'd0;
    end else begin
      r_draw_x      <= w_h_next;
      r_draw_y      <= w_v_next;
      r_blank       <= w_blank_next;
      r_hs          <= w_hs_next;
      r_vs          <= w_vs_next;
      r_frame_start <= w_frame_next;
      if (w_frame_next) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

  // Delayed sync/blank to match the sprite ROM + palette latency downstream.
  generate
    if (PIPE_DLY == 0) begin : g_no_dly
      assign hs_d    = r_hs;
      assign vs_d    = r_vs;
      assign blank_d = r_blank;
    end else begin : g_dly
      logic [PIPE_DLY-1:0] r_hs_pipe;
      logic [PIPE_DLY-1:0] r_vs_pipe;
      logic [PIPE_DLY-1:0] r_blank_pipe;

      // Shift register per signal; stage 0 takes the aligned output.
      always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
          r_hs_pipe    <= '1;
          r_vs_pipe    <= '1;
          r_blank_pipe <= '0;
        end else begin
          r_hs_pipe[0]    <= r_hs;
          r_vs_pipe[0]    <= r_vs;
          r_blank_pipe[0] <= r_blank;
          for (int i = 1; i < PIPE_DLY; i++) begin
            r_hs_pipe[i]    <= r_hs_pipe[i-1];
            r_vs_pipe[i]    <= r_vs_pipe[i-1];
            r_blank_pipe[i] <= r_blank_pipe[i-1];
          end
        end
      end

      assign hs_d    = r_hs_pipe[PIPE_DLY-1];
      assign vs_d    = r_vs_pipe[PIPE_DLY-1];
      assign blank_d = r_blank_pipe[PIPE_DLY-1];
    end
  endgenerate

  assign DrawX       = r_draw_x;
  assign DrawY       = r_draw_y;
  assign blank       = r_blank;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_gen
//  Purpose  : Scoreboard bench. Instance A uses the default 640x480 timing
//             with PIPE_DLY=2; instance B uses a tiny 12x8 raster with
//             PIPE_DLY=0 so that 256 frames fit in a short run.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  typedef struct {
    int cyc;
    int x;
    int y;
    bit bl;
    bit hs;
    bit vs;
    bit fs;
    int fc;
    bit hsd;
    bit vsd;
    bit bld;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  logic [9:0] a_x, a_y, b_x, b_y;
  logic       a_bl, a_hs, a_vs, a_hsd, a_vsd, a_bld, a_fs;
  logic       b_bl, b_hs, b_vs, b_hsd, b_vsd, b_bld, b_fs;
  logic [7:0] a_fc, b_fc;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc_a;
  int   cyc_b;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_async[$];
  event ev_async;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .PIPE_DLY(2)
  ) u_dut_a (
    .vga_clk     (clk),
    .reset       (rst_a),
    .DrawX       (a_x),
    .DrawY       (a_y),
    .blank       (a_bl),
    .hs          (a_hs),
    .vs          (a_vs),
    .hs_d        (a_hsd),
    .vs_d        (a_vsd),
    .blank_d     (a_bld),
    .frame_start (a_fs),
    .frame_count (a_fc)
  );

  // 12 clocks per line (hs low on x 7..8), 8 lines per frame (vs low on y 5..6).
  vga_timing_gen #(
    .H_VISIBLE(6), .H_FP(1), .H_SYNC(2), .H_BP(3),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .PIPE_DLY (0)
  ) u_dut_b (
    .vga_clk     (clk),
    .reset       (rst_b),
    .DrawX       (b_x),
    .DrawY       (b_y),
    .blank       (b_bl),
    .hs          (b_hs),
    .vs          (b_vs),
    .hs_d        (b_hsd),
    .vs_d        (b_vsd),
    .blank_d     (b_bld),
    .frame_start (b_fs),
    .frame_count (b_fc)
  );

  // Cycle index since reset release: edge 1 is the first edge after release.
  always @(posedge clk or posedge rst_a) begin
    if (rst_a) cyc_a <= 0;
    else       cyc_a <= cyc_a + 1;
  end

  always @(posedge clk or posedge rst_b) begin
    if (rst_b) cyc_b <= 0;
    else       cyc_b <= cyc_b + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp_rec(input string tag, input exp_t e,
                         input logic [9:0] x, input logic [9:0] y,
                         input logic bl, input logic hs, input logic vs,
                         input logic fs, input logic [7:0] fc,
                         input logic hsd, input logic vsd, input logic bld);
    string p;
    p = $sformatf("%s@%0d", tag, e.cyc);
    chk({p, " DrawX"},       32'(x),   32'(e.x));
    chk({p, " DrawY"},       32'(y),   32'(e.y));
    chk({p, " blank"},       32'(bl),  32'(e.bl));
    chk({p, " hs"},          32'(hs),  32'(e.hs));
    chk({p, " vs"},          32'(vs),  32'(e.vs));
    chk({p, " frame_start"}, 32'(fs),  32'(e.fs));
    chk({p, " frame_count"}, 32'(fc),  32'(e.fc));
    chk({p, " hs_d"},        32'(hsd), 32'(e.hsd));
    chk({p, " vs_d"},        32'(vsd), 32'(e.vsd));
    chk({p, " blank_d"},     32'(bld), 32'(e.bld));
  endtask

  function automatic exp_t mk(int c, int x, int y, bit bl, bit hs, bit vs, bit fs,
                              int fc, bit hsd, bit vsd, bit bld);
    exp_t e;
    e.cyc = c; e.x = x; e.y = y; e.bl = bl; e.hs = hs; e.vs = vs;
    e.fs = fs; e.fc = fc; e.hsd = hsd; e.vsd = vsd; e.bld = bld;
    return e;
  endfunction

  // Instance B has no delay, so the delayed outputs expect the aligned values.
  task automatic push_b(int c, int x, int y, bit bl, bit hs, bit vs, bit fs, int fc);
    q_b.push_back(mk(c, x, y, bl, hs, vs, fs, fc, hs, vs, bl));
  endtask

  // Monitor A: scoreboard pops plus hs low-width check.
  initial begin : mon_a
    exp_t e;
    int   hs_run;
    hs_run = 0;
    forever begin
      @(negedge clk);
      if (!rst_a) begin
        while (q_a.size() > 0 && q_a[0].cyc <= cyc_a) begin
          e = q_a.pop_front();
          if (e.cyc != cyc_a) begin
            n_tests++; n_fail++;
            $display("FAIL A missed check: got cycle %0d, expected cycle %0d", cyc_a, e.cyc);
          end else begin
            cmp_rec("A", e, a_x, a_y, a_bl, a_hs, a_vs, a_fs, a_fc, a_hsd, a_vsd, a_bld);
          end
        end
        if (a_hs === 1'b0) hs_run++;
        else if (hs_run != 0) begin
          chk("A hs low width", 32'(hs_run), 32'd96);
          hs_run = 0;
        end
      end else begin
        hs_run = 0;
      end
    end
  end

  // Monitor B: scoreboard pops plus frame period, frame_start width, vs width.
  initial begin : mon_b
    exp_t e;
    int   fs_run, last_fs, vs_run;
    fs_run = 0; last_fs = 0; vs_run = 0;
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        while (q_b.size() > 0 && q_b[0].cyc <= cyc_b) begin
          e = q_b.pop_front();
          if (e.cyc != cyc_b) begin
            n_tests++; n_fail++;
            $display("FAIL B missed check: got cycle %0d, expected cycle %0d", cyc_b, e.cyc);
          end else begin
            cmp_rec("B", e, b_x, b_y, b_bl, b_hs, b_vs, b_fs, b_fc, b_hsd, b_vsd, b_bld);
          end
        end
        if (b_fs === 1'b1) begin
          if (fs_run == 0) begin
            if (last_fs != 0) chk("B frame period", 32'(cyc_b - last_fs), 32'd96);
            last_fs = cyc_b;
          end
          fs_run++;
        end else if (fs_run != 0) begin
          chk("B frame_start width", 32'(fs_run), 32'd1);
          fs_run = 0;
        end
        if (b_vs === 1'b0) vs_run++;
        else if (vs_run != 0) begin
          chk("B vs low width", 32'(vs_run), 32'd24);
          vs_run = 0;
        end
      end
    end
  end

  // Monitor for checks taken between clock edges (asynchronous reset).
  initial begin : mon_async
    exp_t e;
    forever begin
      @(ev_async);
      while (q_async.size() > 0) begin
        e = q_async.pop_front();
        cmp_rec("RST", e, a_x, a_y, a_bl, a_hs, a_vs, a_fs, a_fc, a_hsd, a_vsd, a_bld);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  // Stimulus: push hand-computed expectations, then drive reset.
  initial begin : stim
    rst_a = 1'b1;
    rst_b = 1'b1;

    //               cyc  x    y  bl hs vs fs fc hsd vsd bld
    q_a.push_back(mk(1,    0,  0, 1, 1, 1, 1, 1, 1, 1, 0));
    q_a.push_back(mk(2,    1,  0, 1, 1, 1, 0, 1, 1, 1, 0));
    q_a.push_back(mk(3,    2,  0, 1, 1, 1, 0, 1, 1, 1, 1));
    q_a.push_back(mk(640,  639, 0, 1, 1, 1, 0, 1, 1, 1, 1));
    q_a.push_back(mk(641,  640, 0, 0, 1, 1, 0, 1, 1, 1, 1));
    q_a.push_back(mk(643,  642, 0, 0, 1, 1, 0, 1, 1, 1, 0));
    q_a.push_back(mk(657,  656, 0, 0, 0, 1, 0, 1, 1, 1, 0));
    q_a.push_back(mk(659,  658, 0, 0, 0, 1, 0, 1, 0, 1, 0));
    q_a.push_back(mk(752,  751, 0, 0, 0, 1, 0, 1, 0, 1, 0));
    q_a.push_back(mk(753,  752, 0, 0, 1, 1, 0, 1, 0, 1, 0));
    q_a.push_back(mk(755,  754, 0, 0, 1, 1, 0, 1, 1, 1, 0));
    q_a.push_back(mk(800,  799, 0, 0, 1, 1, 0, 1, 1, 1, 0));
    q_a.push_back(mk(801,  0,  1, 1, 1, 1, 0, 1, 1, 1, 0));
    q_a.push_back(mk(803,  2,  1, 1, 1, 1, 0, 1, 1, 1, 1));
    q_a.push_back(mk(1501, 700, 1, 0, 0, 1, 0, 1, 0, 1, 0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;

    // Run to DrawX=700 on line 1 (inside hs), then reset between edges.
    repeat (1501) @(posedge clk);
    @(negedge clk);
    #2;
    rst_a = 1'b1;
    q_async.push_back(mk(0, 799, 524, 0, 1, 1, 0, 0, 1, 1, 0));
    #1;
    -> ev_async;

    // Still held after several edges.
    repeat (3) @(posedge clk);
    #1;
    q_async.push_back(mk(0, 799, 524, 0, 1, 1, 0, 0, 1, 1, 0));
    -> ev_async;

    // Restart from reset: same first-frame sequence, frame_count from 1.
    q_a.push_back(mk(1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0));
    q_a.push_back(mk(2, 1, 0, 1, 1, 1, 0, 1, 1, 1, 0));
    q_a.push_back(mk(3, 2, 0, 1, 1, 1, 0, 1, 1, 1, 1));
    @(negedge clk);
    rst_a = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    rst_a = 1'b1;

    //     cyc    x   y  bl hs vs fs fc
    push_b(1,     0,  0, 1, 1, 1, 1, 1);
    push_b(2,     1,  0, 1, 1, 1, 0, 1);
    push_b(6,     5,  0, 1, 1, 1, 0, 1);
    push_b(7,     6,  0, 0, 1, 1, 0, 1);
    push_b(8,     7,  0, 0, 0, 1, 0, 1);
    push_b(9,     8,  0, 0, 0, 1, 0, 1);
    push_b(10,    9,  0, 0, 1, 1, 0, 1);
    push_b(12,    11, 0, 0, 1, 1, 0, 1);
    push_b(13,    0,  1, 1, 1, 1, 0, 1);
    push_b(37,    0,  3, 1, 1, 1, 0, 1);
    push_b(49,    0,  4, 0, 1, 1, 0, 1);
    push_b(60,    11, 4, 0, 1, 1, 0, 1);
    push_b(61,    0,  5, 0, 1, 0, 0, 1);
    push_b(84,    11, 6, 0, 1, 0, 0, 1);
    push_b(85,    0,  7, 0, 1, 1, 0, 1);
    push_b(96,    11, 7, 0, 1, 1, 0, 1);
    push_b(97,    0,  0, 1, 1, 1, 1, 2);
    push_b(98,    1,  0, 1, 1, 1, 0, 2);
    push_b(24385, 0,  0, 1, 1, 1, 1, 255);
    push_b(24480, 11, 7, 0, 1, 1, 0, 255);
    push_b(24481, 0,  0, 1, 1, 1, 1, 0);
    push_b(24482, 1,  0, 1, 1, 1, 0, 0);

    @(negedge clk);
    rst_b = 1'b0;
    repeat (24490) @(posedge clk);
    @(negedge clk);
    #1;

    chk("A queue drained",     32'(q_a.size()),     32'd0);
    chk("B queue drained",     32'(q_b.size()),     32'd0);
    chk("async queue drained", 32'(q_async.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
